wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter feeding the single write port of `reg_file`. It accepts completed results from two producers (ALU and memory load path) over valid/ready handshakes, buffers one result per producer, and serialises them onto the register-file `wr`/`select`/`data` write port. It also keeps a pending-write scoreboard that the issue stage uses to stall on read-after-write hazards.

## Interface
Parameters:
- `width`, 32, data width of a register
- `numRegs`, 32, number of architectural registers
- `abits`, 5, register index width
- `ZERO_REG`, 31, hardwired-zero register index; writes to it are discarded

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `alu_valid`  in  1  ALU result present
- `alu_ready`  out  1  ALU result accepted this cycle when high with `alu_valid`
- `alu_sel`  in  abits  ALU destination register
- `alu_data`  in  width  ALU result
- `mem_valid`, `mem_ready`, `mem_sel`, `mem_data`: same as the ALU ports, for the load path
- `pend_set`  in  1  issue stage marks `pend_sel` as awaiting writeback
- `pend_sel`  in  abits  register being marked pending
- `wr`  out  1  register-file write enable (registered)
- `wsel`  out  abits  register-file write index (registered)
- `wdata`  out  width  register-file write data (registered)
- `pending`  out  numRegs  scoreboard, bit i high means a write to register i is outstanding

## Operation
- Each source has a one-entry holding register (`h_alu`, `h_mem`: valid, sel, data).
- Accept: `x_ready = !h_x.valid || grant_x`. `x_valid && x_ready` at an edge loads `h_x`. A simultaneous grant and new accept on the same source replaces the entry and leaves it valid.
- Arbitration (combinational, evaluated every cycle): if exactly one holding register is valid, that register gets the grant. If both are valid, the winner is set by priority (see Configuration). Exactly one grant per cycle at most.
- Commit: at the edge, the granted entry is copied to `wsel`/`wdata` and cleared. `wr` <= 1 only if the granted sel != `ZERO_REG`. A `ZERO_REG` entry is consumed with `wr` <= 0. With no grant, `wr` <= 0 and `wsel`/`wdata` hold their values.
- Scoreboard: `pend_set` sets `pending[pend_sel]` at the edge, except when `pend_sel == ZERO_REG`. A cycle with `wr` high clears `pending[wsel]` at the edge. If set and clear hit the same index in the same cycle, set wins.
- `pending[ZERO_REG]` is constantly 0.
- Ordering between the two sources for the same destination is not resolved here. Issue must not have two outstanding writes to one register; it enforces this using `pending`.

## Timing
- Reset values: `wr`=0, `wsel`=0, `wdata`=0, `pending`=0, both holding registers invalid. As a result, `alu_ready`=`mem_ready`=1 in the first cycle after reset.
- Reset mid-operation discards buffered results and clears the scoreboard. Handshakes presented during reset are not accepted.
- Latency: a result accepted at edge N, if granted in cycle N..N+1, is presented with `wr` high during cycle N+1→N+2. The register file captures it at edge N+2. `pending` clears at edge N+2.
- Throughput: one commit per cycle. Under sustained contention, the losing source sees `x_ready`=0 until it is granted.
- `x_ready` depends combinationally on `h_*` state only, not on `x_valid` of the same cycle.

## Configuration
- `WB_RR_EN` undefined: fixed priority, with mem winning over ALU on contention. The ALU can starve under back-to-back loads.
- `WB_RR_EN` defined: round-robin on contention. A 1-bit `last` register (reset to ALU) records the source of the most recent contended grant, and the other source wins the next contended cycle. An uncontended grant does not update `last`.

## Test plan
- Reset then single ALU write: `alu_valid`=1, sel=3, data=0xDEADBEEF for one cycle. Required: `wr`=1, `wsel`=3, `wdata`=0xDEADBEEF exactly one cycle later, then `wr`=0.
- Contention: both sources valid every cycle for 4 cycles (ALU sel=1, mem sel=2).
  - Without `WB_RR_EN`: commit order is mem,mem,mem,mem and `alu_ready` stays low.
  - With `WB_RR_EN`: commit order is mem,alu,mem,alu.
- Zero register: ALU write to sel=31. Required: `alu_ready`=1 on the following cycle, `wr` never asserted, `pending[31]` remains 0 even after `pend_set` with `pend_sel`=31.
- Scoreboard: `pend_set` sel=7, then ALU write sel=7 two cycles later. Required: `pending[7]`=1 from the edge after `pend_set` until the edge ending the `wr` cycle, then 0. A `pend_set` sel=7 coinciding with that commit leaves `pending[7]`=1.
- Backpressure/replace: hold `mem_valid` high with new data every cycle while the ALU is idle. Required: one commit per cycle, `mem_ready` constantly 1, data in order.
- Reset mid-operation: both holding registers full and `pending`=0x0000_00F0, then assert `rst` for one cycle. Required: `wr`=0, `pending`=0, both readies high the next cycle, no stale write is ever emitted.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers one ALU and one load result, serialises them onto the
// register-file write port and tracks pending writes. Define WB_RR_EN for round-robin contention.
module wb_arbiter #(
  parameter int unsigned width    = 32,
  parameter int unsigned numRegs  = 32,
  parameter int unsigned abits    = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [abits-1:0]   alu_sel,
  input  logic [width-1:0]   alu_data,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic [abits-1:0]   mem_sel,
  input  logic [width-1:0]   mem_data,
  input  logic               pend_set,
  input  logic [abits-1:0]   pend_sel,
  output logic               wr,
  output logic [abits-1:0]   wsel,
  output logic [width-1:0]   wdata,
  output logic [numRegs-1:0] pending
);

  localparam logic [abits-1:0] ZERO_SEL = abits'(ZERO_REG);

  typedef struct packed {
    logic             valid;
    logic [abits-1:0] sel;
    logic [width-1:0] data;
  } entry_t;

  entry_t             h_alu;
  entry_t             h_mem;
  entry_t             granted;
  logic               grant_alu;
  logic               grant_mem;
  logic               contended;
  logic               any_grant;
  logic [numRegs-1:0] pending_next;

`ifdef WB_RR_EN
  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;
  src_e last;
  src_e last_next;
`endif

  // Grant selection; contention resolved by fixed priority or round-robin
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    contended = h_alu.valid && h_mem.valid;
    if (contended) begin
`ifdef WB_RR_EN
      if (last == SRC_MEM) begin
        grant_alu = 1'b1;
      end else begin
        grant_mem = 1'b1;
      end
`else
      grant_mem = 1'b1;
`endif
    end else begin
      grant_alu = h_alu.valid;
      grant_mem = h_mem.valid;
    end
  end

  assign any_grant = grant_alu || grant_mem;
  assign granted   = grant_mem ? h_mem : h_alu;
  assign alu_ready = !h_alu.valid || grant_alu;
  assign mem_ready = !h_mem.valid || grant_mem;

`ifdef WB_RR_EN
  always_comb begin
    last_next = last;
    if (contended) begin
      last_next = grant_mem ? SRC_MEM : SRC_ALU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= SRC_ALU;
    end else begin
      last <= last_next;
    end
  end
`endif

  // Scoreboard update: commit clears, issue sets, set wins on the same index
  always_comb begin
    pending_next = pending;
    for (int unsigned i = 0; i < numRegs; i++) begin
      if (wr && (wsel == abits'(i))) begin
        pending_next[i] = 1'b0;
      end
      if (pend_set && (pend_sel == abits'(i))) begin
        pending_next[i] = 1'b1;
      end
    end
    pending_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_alu   <= '0;
      h_mem   <= '0;
      wr      <= 1'b0;
      wsel    <= '0;
      wdata   <= '0;
      pending <= '0;
    end else begin
      // A new accept overrides the clear of a just-granted entry
      if (alu_valid && alu_ready) begin
        h_alu <= '{valid: 1'b1, sel: alu_sel, data: alu_data};
      end else if (grant_alu) begin
        h_alu.valid <= 1'b0;
      end
      if (mem_valid && mem_ready) begin
        h_mem <= '{valid: 1'b1, sel: mem_sel, data: mem_data};
      end else if (grant_mem) begin
        h_mem.valid <= 1'b0;
      end
      wr <= any_grant && (granted.sel != ZERO_SEL);
      if (any_grant) begin
        wsel  <= granted.sel;
        wdata <= granted.data;
      end
      pending <= pending_next;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic against a
// cycle-level behavioural model of the arbiter's rules.
module tb_wb_arbiter;

  localparam int unsigned W = 32;
  localparam int unsigned N = 32;
  localparam int unsigned A = 5;
  localparam int unsigned Z = 31;
  localparam logic [A-1:0] ZS = 5'd31;
`ifdef WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         alu_valid, alu_ready, mem_valid, mem_ready, pend_set, wr;
  logic [A-1:0] alu_sel, mem_sel, pend_sel, wsel;
  logic [W-1:0] alu_data, mem_data, wdata;
  logic [N-1:0] pending;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.width(W), .numRegs(N), .abits(A), .ZERO_REG(Z)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_sel(alu_sel), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_sel(mem_sel), .mem_data(mem_data),
    .pend_set(pend_set), .pend_sel(pend_sel),
    .wr(wr), .wsel(wsel), .wdata(wdata), .pending(pending)
  );

  // Reference model: index 0 = ALU, 1 = mem
  logic         hv[2];
  logic [A-1:0] hs[2];
  logic [W-1:0] hd[2];
  logic         m_wr;
  logic [A-1:0] m_wsel;
  logic [W-1:0] m_wdata;
  logic [N-1:0] m_pend;
  int           m_last;

  function automatic int winner();
    if (hv[0] && hv[1]) return RR ? ((m_last == 1) ? 0 : 1) : 1;
    if (hv[1]) return 1;
    if (hv[0]) return 0;
    return -1;
  endfunction

  function automatic logic [71:0] exp_vec();
    int w;
    w = winner();
    return {m_wr, m_wsel, m_wdata, m_pend, (!hv[0] || w == 0), (!hv[1] || w == 1)};
  endfunction

  task automatic model_tick();
    int w;
    logic r0, r1;
    logic [N-1:0] p;
    if (rst) begin
      hv[0] = 1'b0; hv[1] = 1'b0; hs[0] = '0; hs[1] = '0; hd[0] = '0; hd[1] = '0;
      m_wr = 1'b0; m_wsel = '0; m_wdata = '0; m_pend = '0; m_last = 0;
      return;
    end
    w  = winner();
    r0 = !hv[0] || w == 0;
    r1 = !hv[1] || w == 1;
    p  = m_pend;
    if (m_wr) p[m_wsel] = 1'b0;
    if (pend_set && pend_sel != ZS) p[pend_sel] = 1'b1;
    p[Z] = 1'b0;
    m_pend = p;
    if (hv[0] && hv[1]) m_last = w;
    m_wr = 1'b0;
    if (w >= 0) begin
      m_wr    = (hs[w] != ZS);
      m_wsel  = hs[w];
      m_wdata = hd[w];
      hv[w]   = 1'b0;
    end
    if (alu_valid && r0) begin hv[0] = 1'b1; hs[0] = alu_sel; hd[0] = alu_data; end
    if (mem_valid && r1) begin hv[1] = 1'b1; hs[1] = mem_sel; hd[1] = mem_data; end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; mem_valid = 1'b0; pend_set = 1'b0;
    alu_sel = '0; mem_sel = '0; pend_sel = '0; alu_data = '0; mem_data = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    checks++;
    if ({wr, wsel, wdata, pending, alu_ready, mem_ready} !== {1'b0, 5'd0, 32'd0, 32'd0, 2'b11}) begin
      failures++;
      $display("FAIL reset_state got=%h required=%h", {wr, wsel, wdata, pending, alu_ready, mem_ready},
               {1'b0, 5'd0, 32'd0, 32'd0, 2'b11});
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_single_alu();
    logic [W-1:0] exp_d;
    exp_d = 32'hDEADBEEF;
    alu_valid = 1'b1; alu_sel = 5'd3; alu_data = exp_d;
    cycle();
    idle();
    checks++;
    if (wr !== 1'b0) begin failures++; $display("FAIL single_alu_pre wr=%b required=0", wr); end
    cycle();
    checks++;
    if ({wr, wsel, wdata} !== {1'b1, 5'd3, exp_d}) begin
      failures++;
      $display("FAIL single_alu_commit wr=%b wsel=%0d wdata=%h required 1/3/%h", wr, wsel, wdata, exp_d);
    end
    cycle();
    checks++;
    if (wr !== 1'b0) begin failures++; $display("FAIL single_alu_post wr=%b required=0", wr); end
  endtask

  task automatic test_contention();
    logic [A-1:0] ord[$];
    logic [A-1:0] exp_ord[4];
    logic exp_ar;
    exp_ord[0] = 5'd2; exp_ord[1] = RR ? 5'd1 : 5'd2;
    exp_ord[2] = 5'd2; exp_ord[3] = RR ? 5'd1 : 5'd2;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        alu_valid = 1'b1; alu_sel = 5'd1; alu_data = $urandom;
        mem_valid = 1'b1; mem_sel = 5'd2; mem_data = $urandom;
      end else begin
        idle();
      end
      #0;
      checks++;
      if ({wr, wsel, wdata, pending, alu_ready, mem_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL contention_model cyc=%0d got=%h required=%h", i,
                 {wr, wsel, wdata, pending, alu_ready, mem_ready}, exp_vec());
      end
      if (i >= 1 && i <= 3) begin
        exp_ar = RR && (i == 2);
        checks++;
        if (alu_ready !== exp_ar) begin
          failures++;
          $display("FAIL contention_alu_ready cyc=%0d got=%b required=%b", i, alu_ready, exp_ar);
        end
      end
      if (wr === 1'b1) ord.push_back(wsel);
      cycle();
    end
    checks++;
    if (ord.size() < 4) begin
      failures++;
      $display("FAIL contention_count commits=%0d required>=4", ord.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (ord[k] !== exp_ord[k]) begin
          failures++;
          $display("FAIL contention_order idx=%0d wsel=%0d required=%0d", k, ord[k], exp_ord[k]);
        end
      end
    end
  endtask

  task automatic test_zero_reg();
    int wr_seen;
    wr_seen = 0;
    alu_valid = 1'b1; alu_sel = ZS; alu_data = $urandom;
    pend_set = 1'b1; pend_sel = ZS;
    cycle();
    idle();
    checks++;
    if (alu_ready !== 1'b1) begin failures++; $display("FAIL zero_reg_ready got=%b required=1", alu_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({wr, wsel, wdata, pending, alu_ready, mem_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL zero_reg_model cyc=%0d got=%h required=%h", i,
                 {wr, wsel, wdata, pending, alu_ready, mem_ready}, exp_vec());
      end
      if (wr === 1'b1) wr_seen++;
      cycle();
    end
    checks++;
    if (wr_seen != 0 || pending[Z] !== 1'b0) begin
      failures++;
      $display("FAIL zero_reg_effects wr_count=%0d pending31=%b required 0/0", wr_seen, pending[Z]);
    end
  endtask

  task automatic test_scoreboard();
    pend_set = 1'b1; pend_sel = 5'd7;
    cycle();
    idle();
    checks++;
    if (pending[7] !== 1'b1) begin failures++; $display("FAIL sb_set pending7=%b required=1", pending[7]); end
    cycle();
    alu_valid = 1'b1; alu_sel = 5'd7; alu_data = $urandom;
    cycle();
    idle();
    checks++;
    if (pending[7] !== 1'b1) begin failures++; $display("FAIL sb_hold pending7=%b required=1", pending[7]); end
    cycle();
    checks++;
    if ({wr, wsel, pending[7]} !== {1'b1, 5'd7, 1'b1}) begin
      failures++;
      $display("FAIL sb_commit wr=%b wsel=%0d pending7=%b required 1/7/1", wr, wsel, pending[7]);
    end
    cycle();
    checks++;
    if (pending[7] !== 1'b0) begin failures++; $display("FAIL sb_clear pending7=%b required=0", pending[7]); end
    pend_set = 1'b1; pend_sel = 5'd7;
    cycle();
    pend_set = 1'b0;
    alu_valid = 1'b1; alu_sel = 5'd7; alu_data = $urandom;
    cycle();
    idle();
    cycle();
    pend_set = 1'b1; pend_sel = 5'd7;
    checks++;
    if ({wr, wsel} !== {1'b1, 5'd7}) begin
      failures++;
      $display("FAIL sb_commit2 wr=%b wsel=%0d required 1/7", wr, wsel);
    end
    cycle();
    idle();
    checks++;
    if ({pending, m_pend[7]} !== {m_pend, 1'b1}) begin
      failures++;
      $display("FAIL sb_set_wins pending=%h required=%h (bit7 set)", pending, m_pend);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] sent[$];
    logic [W-1:0] seen[$];
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        mem_valid = 1'b1; mem_sel = A'($urandom_range(0, 30)); mem_data = $urandom;
        sent.push_back(mem_data);
      end else begin
        idle();
      end
      #0;
      checks++;
      if ({wr, wsel, wdata, pending, alu_ready, mem_ready} !== exp_vec() || mem_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_model cyc=%0d got=%h required=%h", i,
                 {wr, wsel, wdata, pending, alu_ready, mem_ready}, exp_vec());
      end
      if (wr === 1'b1) seen.push_back(wdata);
      cycle();
    end
    checks++;
    if (seen.size() != sent.size()) begin
      failures++;
      $display("FAIL b2b_count commits=%0d required=%0d", seen.size(), sent.size());
    end else begin
      foreach (sent[k]) begin
        if (seen[k] !== sent[k]) begin
          failures++;
          $display("FAIL b2b_order idx=%0d wdata=%h required=%h", k, seen[k], sent[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int wr_seen;
    wr_seen = 0;
    for (int i = 4; i < 8; i++) begin
      pend_set = 1'b1; pend_sel = A'(i);
      if (i == 7) begin
        alu_valid = 1'b1; alu_sel = 5'd4; alu_data = $urandom;
        mem_valid = 1'b1; mem_sel = 5'd5; mem_data = $urandom;
      end
      cycle();
    end
    pend_set = 1'b0;
    rst = 1'b1;
    checks++;
    if ({pending, alu_ready, mem_ready} !== {32'h0000_00F0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL rst_mid_pre pending=%h ready=%b%b required 000000f0/01", pending, alu_ready, mem_ready);
    end
    cycle();
    rst = 1'b0;
    idle();
    checks++;
    if ({wr, pending, alu_ready, mem_ready} !== {1'b0, 32'd0, 2'b11}) begin
      failures++;
      $display("FAIL rst_mid_post wr=%b pending=%h ready=%b%b required 0/0/11", wr, pending, alu_ready, mem_ready);
    end
    for (int i = 0; i < 4; i++) begin
      if (wr === 1'b1) wr_seen++;
      cycle();
    end
    checks++;
    if (wr_seen != 0) begin failures++; $display("FAIL rst_mid_stale wr_count=%0d required=0", wr_seen); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      alu_valid = $urandom_range(0, 1) == 1;
      alu_sel   = A'($urandom);
      alu_data  = $urandom;
      mem_valid = $urandom_range(0, 2) != 0;
      mem_sel   = A'($urandom);
      mem_data  = $urandom;
      pend_set  = $urandom_range(0, 1) == 1;
      pend_sel  = A'($urandom);
      #0;
      checks++;
      if ({wr, wsel, wdata, pending, alu_ready, mem_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL random_model cyc=%0d got=%h required=%h", i,
                 {wr, wsel, wdata, pending, alu_ready, mem_ready}, exp_vec());
      end
      cycle();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    test_reset();
    test_single_alu();
    test_contention();
    test_zero_reg();
    test_scoreboard();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
